i2s_rx: RTL

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx_if.sv | 26 ++
 rtl/i2s_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_if.sv
// I2S receiver bundle: serial pins in, decoded sample words and status pulses out.
// master is the receiver side; slave is whatever drives the pins and consumes words.
interface i2s_rx_if #(
  parameter int WIDTH = 16
) ();
  logic             sclk;
  logic             lrclk;
  logic             sdin;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             valid;
  logic             chan;
  logic             frame_err;

  // valid and frame_err are single-clk strobes with no back-pressure: the
  // consumer must take left/right/chan in the cycle the strobe is high.
  modport master (
    input  sclk, lrclk, sdin,
    output left, right, valid, chan, frame_err
  );

  modport slave (
    output sclk, lrclk, sdin,
    input  left, right, valid, chan, frame_err
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrclk/sdin in the clk domain and assembles
// MSB-first words into left/right registers, flagging slots cut short by lrclk.
module i2s_rx #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  i2s_rx_if.master   bus,
  output logic [1:0] dbg_state
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  logic sclk_s1, sclk_s2, sclk_d;
  logic lr_s1, lr_s2;
  logic sd_s1, sd_s2;

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] shreg_q, shreg_n;
  logic             cur_ch_q, cur_ch_n;
  logic             lr_prev_q, lr_prev_n;
  logic [WIDTH-1:0] left_q, left_n;
  logic [WIDTH-1:0] right_q, right_n;
  logic             valid_q, valid_n;
  logic             chan_q, chan_n;
  logic             err_q, err_n;

  logic             rise;
  logic             lr_change;
  logic [WIDTH-1:0] shifted;

  // All three pins share the same two-stage depth so lrclk/sdin stay aligned
  // with the detected sclk edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      lr_s1   <= 1'b0;
      lr_s2   <= 1'b0;
      sd_s1   <= 1'b0;
      sd_s2   <= 1'b0;
    end else begin
      sclk_s1 <= bus.sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      lr_s1   <= bus.lrclk;
      lr_s2   <= lr_s1;
      sd_s1   <= bus.sdin;
      sd_s2   <= sd_s1;
    end
  end

  assign rise      = sclk_s2 & ~sclk_d;
  assign lr_change = (lr_s2 != lr_prev_q);
  assign shifted   = {shreg_q[WIDTH-2:0], sd_s2};

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    shreg_n   = shreg_q;
    cur_ch_n  = cur_ch_q;
    lr_prev_n = lr_prev_q;
    left_n    = left_q;
    right_n   = right_q;
    valid_n   = 1'b0;
    chan_n    = chan_q;
    err_n     = 1'b0;

    if (rise) begin
      lr_prev_n = lr_s2;
      case (state_q)
        IDLE: begin
          if (lr_change) begin
            cur_ch_n = lr_s2;
            cnt_n    = '0;
            state_n  = DELAY;
          end
        end

        // The bit on the lrclk-change rise belongs to the previous slot; the
        // rise after it carries the MSB, so it is loaded here as bit one.
        DELAY: begin
          if (lr_change) begin
            err_n    = 1'b1;
            cur_ch_n = lr_s2;
            cnt_n    = '0;
          end else begin
            shreg_n = {{(WIDTH-1){1'b0}}, sd_s2};
            cnt_n   = CW'(1);
            state_n = SHIFT;
          end
        end

        // In standard framing the LSB arrives on the same rise that reveals
        // the next lrclk level, so the word is completed before the change
        // is acted on.
        SHIFT: begin
          shreg_n = shifted;
          cnt_n   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            valid_n = 1'b1;
            chan_n  = cur_ch_q;
            if (cur_ch_q) right_n = shifted;
            else          left_n  = shifted;
            if (lr_change) begin
              cur_ch_n = lr_s2;
              cnt_n    = '0;
              state_n  = DELAY;
            end else begin
              state_n = HOLD;
            end
          end else if (lr_change) begin
            err_n    = 1'b1;
            cur_ch_n = lr_s2;
            cnt_n    = '0;
            state_n  = DELAY;
          end
        end

        HOLD: begin
          if (lr_change) begin
            cur_ch_n = lr_s2;
            cnt_n    = '0;
            state_n  = DELAY;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      cur_ch_q  <= 1'b0;
      lr_prev_q <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      chan_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      shreg_q   <= shreg_n;
      cur_ch_q  <= cur_ch_n;
      lr_prev_q <= lr_prev_n;
      left_q    <= left_n;
      right_q   <= right_n;
      valid_q   <= valid_n;
      chan_q    <= chan_n;
      err_q     <= err_n;
    end
  end

  assign bus.left      = left_q;
  assign bus.right     = right_q;
  assign bus.valid     = valid_q;
  assign bus.chan      = chan_q;
  assign bus.frame_err = err_q;
  assign dbg_state     = state_q;
endmodule
